// File: rtl/note_spawner_pkg.sv
// Shared types for the note spawner: FSM encoding, field widths
// and the packed note record carried through the pending FIFO.
package note_spawner_pkg;

   localparam int LANE_W = 2;
   localparam int SEQ_W  = 8;
   localparam int RND_W  = 10;
   localparam int DENS_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [LANE_W-1:0] lane;
      logic [SEQ_W-1:0]  seq;
   } note_t;

   // Top three random bits form a 1-of-8 bucket compared against density.
   function automatic logic spawn_hit(input logic [DENS_W-1:0] bucket,
                                      input logic [DENS_W-1:0] density);
      return bucket < density;
   endfunction

endpackage

// File: rtl/note_fifo.sv
// First-word-fall-through FIFO for pending notes; a push into a full
// FIFO is accepted only when a pop frees the head in the same cycle.
module note_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is left uncleared on reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/note_spawner.sv
// Beat-driven note generator: on each beat a random draw may spawn a
// numbered note into a pending FIFO that a consumer drains.
module note_spawner
   import note_spawner_pkg::*;
#(
   parameter int BEAT_DIV = 50000,
   parameter int DEPTH    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [RND_W-1:0]       rnd,
   input  logic [DENS_W-1:0]      density,
   output logic                   beat,
   output logic                   note_valid,
   input  logic                   note_ready,
   output logic [LANE_W-1:0]      note_lane,
   output logic [SEQ_W-1:0]       note_seq,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int CNT_W = $clog2(BEAT_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_DIV - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] beat_cnt;
   logic [SEQ_W-1:0] seq;
   logic             spawn;
   logic             accept;
   logic             pop;
   logic             full;
   logic             empty;
   note_t            head;
   note_t            tail;
   logic [4:0]       unused_rnd;

   assign unused_rnd = rnd[6:2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:
            if (enable)
               state_nx = ST_RUN;
         ST_RUN:
            if (!enable)
               state_nx = ST_DRAIN;
         ST_DRAIN:
            if (enable)
               state_nx = ST_RUN;
            else if (count == '0)
               state_nx = ST_IDLE;
         default:
            state_nx = ST_IDLE;
      endcase
   end

   // The counter only advances in RUN, so every entry into RUN
   // restarts a full beat period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         beat_cnt <= '0;
      else if (state != ST_RUN)
         beat_cnt <= '0;
      else if (beat_cnt == LAST)
         beat_cnt <= '0;
      else
         beat_cnt <= beat_cnt + 1'b1;
   end

   assign beat = (state == ST_RUN) && (beat_cnt == LAST);

   assign spawn  = beat && spawn_hit(rnd[RND_W-1 -: DENS_W], density);
   assign pop    = note_valid && note_ready;
   assign accept = spawn && (!full || pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq      <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept)
            seq <= seq + 1'b1;
         if (spawn && !accept)
            overflow <= 1'b1;
      end
   end

   assign tail.lane = rnd[LANE_W-1:0];
   assign tail.seq  = seq;

   note_fifo #(
      .W     ($bits(note_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (pop),
      .din   (tail),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign note_valid = !empty;
   assign note_lane  = head.lane;
   assign note_seq   = head.seq;

endmodule

// File: tb/tb_note_spawner.sv
// Directed bench for note_spawner with BEAT_DIV=4, DEPTH=4.
// Each scenario task checks its own hand-derived expectations.
module tb_note_spawner;
   import note_spawner_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [9:0] rnd = '0;
   logic [2:0] density = '0;
   logic       beat;
   logic       note_valid;
   logic       note_ready = 1'b0;
   logic [1:0] note_lane;
   logic [7:0] note_seq;
   logic [2:0] count;
   logic       overflow;

   int compared = 0;
   int mismatched = 0;

   note_spawner #(.BEAT_DIV(4), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .rnd        (rnd),
      .density    (density),
      .beat       (beat),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note_lane  (note_lane),
      .note_seq   (note_seq),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns cycles until beat is seen, or -1 if the budget expires.
   task automatic wait_beat(input int max, output int n);
      bit got = 0;
      n = 0;
      while (n < max && !got) begin
         tick();
         n++;
         if (beat === 1'b1) got = 1;
      end
      if (!got) n = -1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      enable = 1'b0;
      note_ready = 1'b0;
      density = '0;
      rnd = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      compared++;
      if (count !== 3'd0 || note_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_fifo: count=%0d valid=%b want 0/0", count, note_valid);
      end
      compared++;
      if (beat !== 1'b0 || overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_flags: beat=%b ovf=%b want 0/0", beat, overflow);
      end
      compared++;
      if (dut.state !== ST_IDLE) begin
         mismatched++;
         $display("FAIL reset_state: state=%0d want %0d", dut.state, ST_IDLE);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_fill_overflow();
      int n;
      apply_reset();
      density = 3'd7;
      rnd = 10'b000_0000_010;
      enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_beat(8, n);
         compared++;
         if (n !== 4 || count !== 3'(k)) begin
            mismatched++;
            $display("FAIL fill_beat%0d: n=%0d count=%0d want n=4 count=%0d", k, n, count, k);
         end
      end
      wait_beat(8, n);
      compared++;
      if (n !== 4 || count !== 3'd4 || overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL full_beat: n=%0d count=%0d ovf=%b want 4/4/0", n, count, overflow);
      end
      tick();
      compared++;
      if (count !== 3'd4 || overflow !== 1'b1) begin
         mismatched++;
         $display("FAIL overflow: count=%0d ovf=%b want 4/1", count, overflow);
      end
      compared++;
      if (note_seq !== 8'd0 || note_lane !== 2'd2) begin
         mismatched++;
         $display("FAIL fill_head: seq=%0d lane=%0d want 0/2", note_seq, note_lane);
      end
      note_ready = 1'b1;
      tick();
      note_ready = 1'b0;
      compared++;
      if (count !== 3'd3 || note_seq !== 8'd1) begin
         mismatched++;
         $display("FAIL one_pop: count=%0d seq=%0d want 3/1", count, note_seq);
      end
      wait_beat(8, n);
      compared++;
      if (n !== 2) begin
         mismatched++;
         $display("FAIL refill_beat: n=%0d want 2", n);
      end
      tick();
      compared++;
      if (count !== 3'd4) begin
         mismatched++;
         $display("FAIL refill_count: count=%0d want 4", count);
      end
      enable = 1'b0;
      note_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (note_seq !== 8'(i + 1) || note_lane !== 2'd2) begin
            mismatched++;
            $display("FAIL drain_seq%0d: seq=%0d lane=%0d want %0d/2", i, note_seq, note_lane, i + 1);
         end
         tick();
      end
      note_ready = 1'b0;
      compared++;
      if (count !== 3'd0 || note_valid !== 1'b0 || overflow !== 1'b1) begin
         mismatched++;
         $display("FAIL drain_end: count=%0d valid=%b ovf=%b want 0/0/1", count, note_valid, overflow);
      end
   endtask

   task automatic test_density_zero();
      int n;
      logic [9:0] pat [10] = '{10'h000, 10'h3ff, 10'h155, 10'h2aa, 10'h080,
                               10'h381, 10'h102, 10'h203, 10'h3c0, 10'h07f};
      apply_reset();
      density = 3'd0;
      enable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         rnd = pat[k];
         wait_beat(8, n);
         compared++;
         if (n !== 4 || count !== 3'd0 || note_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL dens0_beat%0d: n=%0d count=%0d valid=%b want 4/0/0", k, n, count, note_valid);
         end
      end
      tick();
      compared++;
      if (count !== 3'd0 || overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL dens0_end: count=%0d ovf=%b want 0/0", count, overflow);
      end
   endtask

   task automatic test_threshold();
      int n;
      apply_reset();
      density = 3'd4;
      rnd = {3'd4, 5'd0, 2'd1};
      enable = 1'b1;
      wait_beat(8, n);
      tick();
      compared++;
      if (n !== 4 || count !== 3'd0) begin
         mismatched++;
         $display("FAIL thr_equal: n=%0d count=%0d want 4/0", n, count);
      end
      rnd = {3'd3, 5'd0, 2'd3};
      wait_beat(8, n);
      tick();
      compared++;
      if (n !== 3 || count !== 3'd1 || note_lane !== 2'd3 || note_seq !== 8'd0) begin
         mismatched++;
         $display("FAIL thr_below: n=%0d count=%0d lane=%0d seq=%0d want 3/1/3/0", n, count, note_lane, note_seq);
      end
      density = 3'd7;
      rnd = {3'd7, 5'd0, 2'd0};
      wait_beat(8, n);
      tick();
      compared++;
      if (count !== 3'd1) begin
         mismatched++;
         $display("FAIL thr_top_equal: count=%0d want 1", count);
      end
      rnd = {3'd6, 5'd0, 2'd2};
      wait_beat(8, n);
      tick();
      compared++;
      if (count !== 3'd2) begin
         mismatched++;
         $display("FAIL thr_top_below: count=%0d want 2", count);
      end
   endtask

   task automatic test_full_pop_push();
      int n;
      apply_reset();
      density = 3'd7;
      rnd = 10'd1;
      enable = 1'b1;
      for (int k = 0; k < 4; k++) wait_beat(8, n);
      tick();
      compared++;
      if (count !== 3'd4) begin
         mismatched++;
         $display("FAIL fp_fill: count=%0d want 4", count);
      end
      wait_beat(8, n);
      note_ready = 1'b1;
      compared++;
      if (n !== 3 || note_seq !== 8'd0) begin
         mismatched++;
         $display("FAIL fp_beat: n=%0d seq=%0d want 3/0", n, note_seq);
      end
      tick();
      note_ready = 1'b0;
      compared++;
      if (count !== 3'd4 || overflow !== 1'b0 || note_seq !== 8'd1) begin
         mismatched++;
         $display("FAIL fp_same_cycle: count=%0d ovf=%b seq=%0d want 4/0/1", count, overflow, note_seq);
      end
      enable = 1'b0;
      note_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (note_seq !== 8'(i + 1) || note_lane !== 2'd1) begin
            mismatched++;
            $display("FAIL fp_order%0d: seq=%0d lane=%0d want %0d/1", i, note_seq, note_lane, i + 1);
         end
         tick();
      end
      note_ready = 1'b0;
   endtask

   task automatic test_drain();
      int n;
      int beats = 0;
      apply_reset();
      density = 3'd7;
      rnd = 10'd0;
      enable = 1'b1;
      for (int k = 0; k < 3; k++) wait_beat(8, n);
      tick();
      enable = 1'b0;
      note_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (beat === 1'b1) beats++;
         compared++;
         if (count !== 3'(2 - i)) begin
            mismatched++;
            $display("FAIL drain_pop%0d: count=%0d want %0d", i, count, 2 - i);
         end
      end
      compared++;
      if (dut.state !== ST_DRAIN) begin
         mismatched++;
         $display("FAIL drain_state: state=%0d want %0d", dut.state, ST_DRAIN);
      end
      tick();
      if (beat === 1'b1) beats++;
      compared++;
      if (dut.state !== ST_IDLE || beats !== 0) begin
         mismatched++;
         $display("FAIL drain_idle: state=%0d beats=%0d want %0d/0", dut.state, beats, ST_IDLE);
      end
      note_ready = 1'b0;
      enable = 1'b1;
      for (int k = 0; k < 3; k++) wait_beat(8, n);
      tick();
      enable = 1'b0;
      note_ready = 1'b1;
      tick();
      compared++;
      if (count !== 3'd2 || dut.state !== ST_DRAIN) begin
         mismatched++;
         $display("FAIL mid_drain: count=%0d state=%0d want 2/%0d", count, dut.state, ST_DRAIN);
      end
      #2 reset = 1'b1;
      #1;
      compared++;
      if (count !== 3'd0 || note_valid !== 1'b0 || dut.state !== ST_IDLE) begin
         mismatched++;
         $display("FAIL async_reset: count=%0d valid=%b state=%0d want 0/0/%0d", count, note_valid, dut.state, ST_IDLE);
      end
      tick();
      reset = 1'b0;
      note_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_density_zero();
      test_threshold();
      test_full_pop_push();
      test_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/note_spawner.md
NOTE_SPAWNER -- requirements
Module: note_spawner

Interface
REQ-001 Parameter BEAT_DIV, default 50000: clock cycles per beat; legal range 2..2^20.
REQ-002 Parameter DEPTH, default 8: pending-note FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  high = run, spawning allowed; low = stop spawning and drain.
REQ-006 rnd  input  10  free-running pseudo-random word from the upstream 10-bit LFSR.
REQ-007 density  input  3  spawn threshold; 0 = never spawn, 7 = spawn on 7 of 8 beats.
REQ-008 beat  output  1  one-cycle pulse at each beat boundary.
REQ-009 note_valid  output  1  head note available.
REQ-010 note_ready  input  1  consumer accepts head note.
REQ-011 note_lane  output  2  lane of head note.
REQ-012 note_seq  output  8  sequence number of head note.
REQ-013 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 overflow  output  1  sticky flag: at least one spawn was dropped.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN; reset state IDLE.
REQ-016 IDLE -> RUN when enable=1; RUN -> DRAIN when enable=0; DRAIN -> IDLE when count=0 and enable=0; DRAIN -> RUN when enable=1.
REQ-017 Beat counter counts 0..BEAT_DIV-1 only in RUN, wraps to 0; held at 0 in IDLE and DRAIN.
REQ-018 beat=1 for exactly the cycle in which the counter equals BEAT_DIV-1 in RUN; first beat comes BEAT_DIV cycles after entering RUN.
REQ-019 On a beat, rnd is sampled that same cycle; a spawn request is raised iff rnd[9:7] < density (unsigned).
REQ-020 Spawned note: lane = rnd[1:0]; seq = internal 8-bit sequence counter, reset to 0, incremented by 1 per accepted spawn, wrapping 255 -> 0.
REQ-021 Spawn accepted if count<DEPTH, or if count=DEPTH and a pop occurs the same cycle; otherwise dropped: overflow set to 1, seq not incremented.
REQ-022 FIFO is first-word-fall-through: note_valid = (count != 0); note_lane/note_seq present head entry combinationally from storage.
REQ-023 Pop occurs when note_valid && note_ready; head advances at the next clock edge.
REQ-024 Simultaneous push and pop: count unchanged; data ordering preserved; push to empty with no pop visible one cycle later.
REQ-025 note_ready while note_valid=0 has no effect; count never underflows or exceeds DEPTH.
REQ-026 Read/write pointers wrap modulo DEPTH.
REQ-027 Pops accepted in all states, including IDLE.
REQ-028 overflow cleared only by reset.

Reset
REQ-029 reset asserted: FSM=IDLE, beat counter=0, seq=0, pointers=0, count=0, overflow=0, beat=0, note_valid=0 immediately (asynchronous).
REQ-030 Reset mid-operation discards all pending notes; FIFO storage contents need not be cleared.
REQ-031 First beat after reset release requires enable=1 and BEAT_DIV full cycles in RUN.

Structure
REQ-032 Shared package holds FSM state encoding (IDLE/RUN/DRAIN), LANE_W=2, SEQ_W=8, RND_W=10.
REQ-033 FIFO is one sub-module, note_fifo (parameterised width and DEPTH, push/pop/full/empty/count); beat counter, FSM and spawn decision stay in note_spawner.

Verification (BEAT_DIV=4, DEPTH=4 unless stated)
REQ-034 enable=1, density=7, rnd=10'b000_0000_010 held, note_ready=0 -> beat every 4 cycles; notes (lane 2, seq 0,1,2,3) queued; count reaches 4.
REQ-035 Continue REQ-034 stimulus one more beat -> count stays 4, overflow=1, next accepted note after one pop carries seq 4.
REQ-036 density=0, any rnd, 10 beats -> beat pulses present, count=0, note_valid=0.
REQ-037 density=4, rnd[9:7]=4 then 3 on successive beats -> first beat no spawn, second beat spawn; boundary rnd[9:7]=density is no-spawn.
REQ-038 FIFO full, note_ready=1 on beat cycle with spawn -> pop and push same cycle, count stays 4, overflow stays 0.
REQ-039 3 notes queued, enable=0, note_ready=1 -> FSM DRAIN, no further beats, 3 pops in 3 cycles, then IDLE; reset asserted mid-drain -> count=0, note_valid=0 same cycle.
